// File: rtl/d_axi_pkg.sv
// Shared definitions for the data-side AXI SRAM responder.
package d_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_BEAT} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Latched AR/AW request; addr advances by one beat as the burst proceeds.
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ax_req_t;

  function automatic logic [31:0] beat_incr(input logic [2:0] size);
    return 32'(1) << size;
  endfunction

endpackage

// File: rtl/d_axi_resp_ram.sv
// Word RAM: registered read port (optionally zero-filled), byte-enabled write port.
module d_axi_resp_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin : ram_wr
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Separate process from the write so a same-cycle hit returns the old word.
  always_ff @(posedge clk or negedge rst) begin : ram_rd
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? 32'h0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/d_axi_sram_responder.sv
// AXI subset slave serving read/write bursts from an internal word RAM.
module d_axi_sram_responder
  import d_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned LW       = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam int unsigned LAT_INIT = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
  localparam logic [32:0] LIMIT    = 33'(BASE_ADDR) + 33'(4 * DEPTH);

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= 33'(BASE_ADDR)) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // Read channel state
  r_state_e      r_state, r_state_d;
  ax_req_t       r_req, r_req_d;
  logic [7:0]    r_cnt, r_cnt_d;
  logic [LW-1:0] lat, lat_d;
  logic          arready_d, rvalid_d, rlast_d;
  logic [1:0]    rresp_d;
  logic          fetch_en, fetch_err;
  logic [31:0]   fetch_addr;
  logic [2:0]    fetch_size;

  // Write channel state
  w_state_e      w_state, w_state_d;
  ax_req_t       w_req, w_req_d;
  logic [7:0]    w_cnt, w_cnt_d;
  logic          w_err, w_err_d;
  logic          awready_d, wready_d, bvalid_d;
  logic [1:0]    bresp_d;
  logic          beat_err, ram_we;

  always_comb begin : r_next
    r_state_d  = r_state;
    r_req_d    = r_req;
    r_cnt_d    = r_cnt;
    lat_d      = lat;
    arready_d  = arready;
    rvalid_d   = rvalid;
    rlast_d    = rlast;
    rresp_d    = rresp;
    fetch_en   = 1'b0;
    fetch_addr = r_req.addr;
    fetch_size = r_req.size;
    unique case (r_state)
      R_IDLE: begin
        if (arvalid) begin
          r_req_d   = '{addr: araddr, len: arlen, size: arsize};
          r_cnt_d   = '0;
          arready_d = 1'b0;
          if (RD_LAT <= 1) begin
            fetch_en   = 1'b1;
            fetch_addr = araddr;
            fetch_size = arsize;
            r_state_d  = R_BEAT;
            rvalid_d   = 1'b1;
            rlast_d    = (arlen == 8'd0);
          end else begin
            lat_d     = LW'(LAT_INIT);
            r_state_d = R_LAT;
          end
        end
      end
      R_LAT: begin
        if (lat == '0) begin
          fetch_en  = 1'b1;
          r_state_d = R_BEAT;
          rvalid_d  = 1'b1;
          rlast_d   = (r_req.len == 8'd0);
        end else begin
          lat_d = lat - LW'(1);
        end
      end
      R_BEAT: begin
        if (rready) begin
          if (r_cnt == r_req.len) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            fetch_en       = 1'b1;
            fetch_addr     = r_req.addr + beat_incr(r_req.size);
            r_req_d.addr   = fetch_addr;
            r_cnt_d        = r_cnt + 8'd1;
            rlast_d        = (r_cnt_d == r_req.len);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    fetch_err = !in_range(fetch_addr) || (fetch_size > SIZE_WORD);
    if (fetch_en) rresp_d = fetch_err ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst) begin : r_regs
    if (!rst) begin
      r_state <= R_IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
      lat     <= '0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_d;
      r_req   <= r_req_d;
      r_cnt   <= r_cnt_d;
      lat     <= lat_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rlast   <= rlast_d;
      rresp   <= rresp_d;
    end
  end

  always_comb begin : w_next
    w_state_d = w_state;
    w_req_d   = w_req;
    w_cnt_d   = w_cnt;
    w_err_d   = w_err;
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    ram_we    = 1'b0;
    beat_err  = !in_range(w_req.addr) || (w_req.size > SIZE_WORD);
    unique case (w_state)
      W_IDLE: begin
        if (awvalid) begin
          w_req_d   = '{addr: awaddr, len: awlen, size: awsize};
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          ram_we  = !beat_err;
          // A beat is malformed if wlast disagrees with the announced length.
          w_err_d = w_err | beat_err | (wlast != (w_cnt == w_req.len));
          if (wlast) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_req_d.addr = w_req.addr + beat_incr(w_req.size);
            w_cnt_d      = w_cnt + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin : w_regs
    if (!rst) begin
      w_state <= W_IDLE;
      w_req   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      w_state <= w_state_d;
      w_req   <= w_req_d;
      w_cnt   <= w_cnt_d;
      w_err   <= w_err_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
    end
  end

  d_axi_resp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (fetch_en),
    .rd_zero (fetch_err),
    .rd_addr (word_idx(fetch_addr)),
    .rd_data (rdata),
    .wr_en   (ram_we),
    .wr_addr (word_idx(w_req.addr)),
    .wr_data (wdata),
    .wr_be   (wstrb)
  );

endmodule

// File: tb/tb_d_axi_sram_responder.sv
// Self-checking bench: directed table, hand sequences and random bursts against a word-array model.
module tb_d_axi_sram_responder;
  import d_axi_pkg::*;

  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;

  d_axi_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;
  logic [1:0]  last_bresp;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] off;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] pre;
    logic [31:0] exp_word;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit m_ok(input logic [31:0] a, input logic [2:0] size);
    longint la;
    la = longint'(a);
    return (size <= 3'd2) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Beats 0..last_at are sent from wd/ws; the model is updated from the address rules first.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input int last_at, input int bwait, input bit chk_hold);
    bit err;
    logic [1:0] exp_resp;
    logic [31:0] a;
    int g;
    err = (last_at != int'(len));
    for (int i = 0; i <= last_at; i++) begin
      a = addr + 32'(i) * (32'd1 << size);
      if (m_ok(a, size)) begin
        for (int b = 0; b < 4; b++) if (ws[i][b]) model[m_idx(a)][b*8 +: 8] = wd[i][b*8 +: 8];
      end else err = 1'b1;
    end
    exp_resp = err ? RESP_SLVERR : RESP_OKAY;
    @(negedge clk);
    awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    g = 0;
    while (!awready && g < 50) begin @(negedge clk); g++; end
    if (!awready) check("aw_timeout", 32'(awready), 32'd1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
      g = 0;
      while (!wready && g < 50) begin @(negedge clk); g++; end
      if (!wready) check("w_timeout", 32'(wready), 32'd1);
      @(posedge clk); @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0;
    for (int k = 0; k < bwait; k++) begin
      if (chk_hold) begin
        check("bvalid_hold", 32'(bvalid), 32'd1);
        check("awready_while_b", 32'(awready), 32'd0);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    g = 0;
    while (!bvalid && g < 50) begin @(negedge clk); g++; end
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(exp_resp));
    last_bresp = bresp;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    check("awready_after_b", 32'(awready), 32'd1);
  endtask

  // mode 0: rready always 1, 1: toggling, 2: random
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int mode);
    int beat, cyc, first, g;
    bit rr;
    logic [31:0] a, exp_d;
    logic [1:0] exp_r;
    @(negedge clk);
    araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    g = 0;
    while (!arready && g < 50) begin @(negedge clk); g++; end
    if (!arready) check("ar_timeout", 32'(arready), 32'd1);
    @(posedge clk);
    beat = 0; cyc = 0; first = -1;
    while (beat <= int'(len) && cyc < 2000) begin
      @(negedge clk);
      arvalid = 1'b0;
      cyc++;
      case (mode)
        0: rr = 1'b1;
        1: rr = cyc[0];
        default: rr = 1'($urandom_range(0, 1));
      endcase
      rready = rr;
      if (rvalid) begin
        if (first < 0) begin
          first = cyc;
          check("rd_latency", 32'(first), 32'(RD_LAT));
        end
        a = addr + 32'(beat) * (32'd1 << size);
        if (m_ok(a, size)) begin exp_d = model[m_idx(a)]; exp_r = RESP_OKAY; end
        else begin exp_d = 32'h0; exp_r = RESP_SLVERR; end
        check("rdata", rdata, exp_d);
        check("rresp", 32'(rresp), 32'(exp_r));
        check("rlast", 32'(rlast), 32'(beat == int'(len)));
        last_rdata = rdata;
        if (rr) beat++;
      end
    end
    check("r_beats", 32'(beat), 32'(int'(len) + 1));
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_end", 32'(rvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    last_rdata = '0; last_bresp = '0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    vecs[0] = '{32'h06, 3'd0, 4'b0100, 32'h00AB_0000, 32'h1122_3344, 32'h11AB_3344, RESP_OKAY};
    vecs[1] = '{32'h0A, 3'd1, 4'b1100, 32'hBEEF_0000, 32'h0123_4567, 32'hBEEF_4567, RESP_OKAY};
    vecs[2] = '{32'h0C, 3'd2, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, RESP_OKAY};
    vecs[3] = '{32'h11, 3'd0, 4'b0001, 32'h0000_00AA, 32'h5566_7788, 32'h5566_77AA, RESP_OKAY};
    vecs[4] = '{32'h14, 3'd3, 4'b1111, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, RESP_SLVERR};
    vecs[5] = '{32'hFC, 3'd2, 4'b0011, 32'h0000_BBCC, 32'hAAAA_AAAA, 32'hAAAA_BBCC, RESP_OKAY};

    repeat (3) @(negedge clk);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fill the whole RAM so every later read has a defined expectation.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(BASE + 32'(blk * 64), 8'd15, 3'd2, 15, 0, 1'b0);
    end

    // Single uncached read of a known word
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(BASE + 32'h10, 8'd0, 3'd2, 0, 0, 1'b0);
    do_read(BASE + 32'h10, 8'd0, 3'd2, 0);
    check("t1_rdata", last_rdata, 32'hDEAD_BEEF);

    // Narrow / unaligned / illegal-size single writes from the table
    for (int v = 0; v < 6; v++) begin
      wd[0] = vecs[v].pre; ws[0] = 4'hF;
      do_write(BASE + (vecs[v].off & 32'hFFFF_FFFC), 8'd0, 3'd2, 0, 0, 1'b0);
      wd[0] = vecs[v].data; ws[0] = vecs[v].strb;
      do_write(BASE + vecs[v].off, 8'd0, vecs[v].size, 0, 0, 1'b0);
      check("tbl_bresp", 32'(last_bresp), 32'(vecs[v].exp_resp));
      do_read(BASE + (vecs[v].off & 32'hFFFF_FFFC), 8'd0, 3'd2, 0);
      check("tbl_word", last_rdata, vecs[v].exp_word);
    end

    // Line fill with toggling rready
    do_read(BASE + 32'h20, 8'd7, 3'd2, 1);

    // 4-beat writeback with delayed bready, then readback
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(BASE + 32'h80, 8'd3, 3'd2, 3, 5, 1'b1);
    do_read(BASE + 32'h80, 8'd3, 3'd2, 2);

    // Out of range, and address wrap past 2^32
    do_read(BASE + 32'(4 * DEPTH), 8'd1, 3'd2, 0);
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(BASE + 32'(4 * DEPTH), 8'd1, 3'd2, 1, 0, 1'b0);
    check("oob_bresp", 32'(last_bresp), 32'(RESP_SLVERR));
    do_read(32'hFFFF_FFFC, 8'd1, 3'd2, 0);

    // Early and late wlast
    for (int i = 0; i < 5; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(BASE + 32'h40, 8'd3, 3'd2, 1, 0, 1'b0);
    check("early_wlast_bresp", 32'(last_bresp), 32'(RESP_SLVERR));
    do_write(BASE + 32'h50, 8'd3, 3'd2, 4, 1, 1'b1);
    do_read(BASE + 32'h40, 8'd7, 3'd2, 0);

    // Reset in the middle of a read burst
    @(negedge clk);
    araddr = BASE + 32'h20; arlen = 8'd7; arsize = 3'd2; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rvalid", 32'(rvalid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_rlast", 32'(rlast), 32'd0);
    rready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_read(BASE + 32'h30, 8'd3, 3'd2, 0);

    // Random bursts against the model
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  sz;
      int last;
      a   = BASE - 32'd8 + 32'($urandom_range(0, 4 * DEPTH + 16));
      sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      len = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 9; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        last = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : int'(len);
        do_write(a, len, sz, last, int'($urandom_range(0, 3)), 1'b1);
      end else begin
        do_read(a, len, sz, 2);
      end
    end

    // Full readback confirms nothing outside the model changed
    for (int blk = 0; blk < 4; blk++) do_read(BASE + 32'(blk * 64), 8'd15, 3'd2, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
